wb_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back select for the 5-stage MIPS core; sits directly upstream of RF.

---
 rtl/wb_stage_pkg.sv | 21 ++
 rtl/wb_stage_if.sv | 39 +++
 rtl/wb_stage_load_align.sv | 29 ++
 rtl/wb_stage.sv | 93 +++++++++
 tb/tb_wb_stage.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared write-back select codes, load type codes and register-file constants
package wb_stage_pkg;

    localparam int GPR_COUNT = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;
    localparam logic [1:0] WB_SEL_RSVD = 2'd3;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LW  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    function automatic logic load_type_known(input logic [2:0] t);
        return t == LD_LB || t == LD_LH || t == LD_LW || t == LD_LBU || t == LD_LHU;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-side inputs and RF/bypass outputs of the write-back stage
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_reg_write;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [1:0]        mem_wb_sel;
    logic [2:0]        mem_load_type;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_load_data;
    logic [DATA_W-1:0] mem_pc_plus4;
    logic [ADDR_W-1:0] RdAddr;
    logic [DATA_W-1:0] RdData;
    logic              RegWrite;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic              misalign_err;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_load_type, mem_alu_result, mem_load_data, mem_pc_plus4,
        input  RdAddr, RdData, RegWrite, fwd_valid, fwd_addr, fwd_data,
               misalign_err, retired_count
    );

    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_load_type, mem_alu_result, mem_load_data, mem_pc_plus4,
        output RdAddr, RdData, RegWrite, fwd_valid, fwd_addr, fwd_data,
               misalign_err, retired_count
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: little-endian byte/half/word select with sign/zero extension and misalignment detect
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addr,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] value,
    output logic              misalign
);
    logic [7:0]  b;
    logic [15:0] h;

    // pick the addressed lane, then extend according to the load type
    always_comb begin
        b = word[{addr, 3'b000} +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        value = load_type == LD_LB  ? {{(DATA_W-8){b[7]}}, b} :
                load_type == LD_LBU ? {{(DATA_W-8){1'b0}}, b} :
                load_type == LD_LH  ? {{(DATA_W-16){h[15]}}, h} :
                load_type == LD_LHU ? {{(DATA_W-16){1'b0}}, h} :
                load_type == LD_LW  ? word : '0;
        misalign = ((load_type == LD_LH || load_type == LD_LHU) && addr[0]) ||
                   (load_type == LD_LW && addr != 2'd0) ||
                   !load_type_known(load_type);
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, write-back select, RF write gating and retire counter
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input logic    clk,
    input logic    rst_n,
    wb_stage_if.slave bus
);
    logic              valid;
    logic              reg_write;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        wb_sel;
    logic [2:0]        load_type;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] pc_plus4;
    logic [CNT_W-1:0]  retired_count;
    logic [DATA_W-1:0] aligned;
    logic              ld_misalign;
    logic              misalign_err;
    logic [DATA_W-1:0] rd_data;
    logic              write_en;

    // pipeline register: flush loads a bubble and beats stall, stall holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            reg_write  <= 1'b0;
            rd_addr    <= '0;
            wb_sel     <= '0;
            load_type  <= '0;
            alu_result <= '0;
            load_data  <= '0;
            pc_plus4   <= '0;
        end else if (bus.flush) begin
            valid      <= 1'b0;
            reg_write  <= 1'b0;
            rd_addr    <= '0;
            wb_sel     <= '0;
            load_type  <= '0;
            alu_result <= '0;
            load_data  <= '0;
            pc_plus4   <= '0;
        end else if (!bus.stall) begin
            valid      <= bus.mem_valid;
            reg_write  <= bus.mem_reg_write;
            rd_addr    <= bus.mem_rd_addr;
            wb_sel     <= bus.mem_wb_sel;
            load_type  <= bus.mem_load_type;
            alu_result <= bus.mem_alu_result;
            load_data  <= bus.mem_load_data;
            pc_plus4   <= bus.mem_pc_plus4;
        end
    end

    // count every real instruction that actually enters the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_count <= '0;
        else if (!bus.flush && !bus.stall && bus.mem_valid)
            retired_count <= retired_count + CNT_W'(1);
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .word      (load_data),
        .addr      (alu_result[1:0]),
        .load_type (load_type),
        .value     (aligned),
        .misalign  (ld_misalign)
    );

    // result select and write gating; R0 and faulting loads never reach the RF
    always_comb begin
        misalign_err = valid && wb_sel == WB_SEL_LOAD && ld_misalign;
        rd_data = wb_sel == WB_SEL_ALU  ? alu_result :
                  wb_sel == WB_SEL_LOAD ? aligned :
                  wb_sel == WB_SEL_LINK ? pc_plus4 : '0;
        write_en = valid && reg_write && rd_addr != '0 && !misalign_err && wb_sel != WB_SEL_RSVD;
    end

    assign bus.RdAddr        = rd_addr;
    assign bus.RdData        = rd_data;
    assign bus.RegWrite      = write_en;
    assign bus.fwd_valid     = write_en;
    assign bus.fwd_addr      = rd_addr;
    assign bus.fwd_data      = rd_data;
    assign bus.misalign_err  = misalign_err;
    assign bus.retired_count = retired_count;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of capture, load alignment, gating, stall/flush and counter wrap
module tb_wb_stage;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) bus ();

    wb_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc);
        bus.mem_valid      = v;
        bus.mem_reg_write  = rw;
        bus.mem_rd_addr    = rd;
        bus.mem_wb_sel     = sel;
        bus.mem_load_type  = lt;
        bus.mem_alu_result = alu;
        bus.mem_load_data  = ld;
        bus.mem_pc_plus4   = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] data, input logic mis, input logic [CW-1:0] cnt);
        chk({tag, ".RegWrite"}, 64'(bus.RegWrite), 64'(we));
        chk({tag, ".RdAddr"}, 64'(bus.RdAddr), 64'(rd));
        chk({tag, ".RdData"}, 64'(bus.RdData), 64'(data));
        chk({tag, ".fwd"}, {bus.fwd_valid, 26'd0, bus.fwd_addr, bus.fwd_data}, {we, 26'd0, rd, data});
        chk({tag, ".misalign"}, 64'(bus.misalign_err), 64'(mis));
        chk({tag, ".count"}, 64'(bus.retired_count), 64'(cnt));
    endtask

    localparam logic [31:0] LDW = 32'h80FF_7F01;

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk_out("reset_hold", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(1, 1, 5'd1, 2'd0, 3'd0, 32'h11, 0, 0);
        step();
        chk_out("pre_reset", 1, 1, 32'h11, 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        step();
        chk_out("after_release", 0, 0, 0, 0, 0);

        drive(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 0, 0);
        step();
        chk_out("alu", 1, 5, 32'h1234_5678, 0, 1);

        drive(1, 1, 5'd6, 2'd1, 3'd0, 32'h1000_0003, LDW, 0);
        step();
        chk_out("lb3", 1, 6, 32'hFFFF_FF80, 0, 2);
        drive(1, 1, 5'd6, 2'd1, 3'd4, 32'h1000_0001, LDW, 0);
        step();
        chk_out("lbu1", 1, 6, 32'h0000_007F, 0, 3);
        drive(1, 1, 5'd6, 2'd1, 3'd1, 32'h1000_0002, LDW, 0);
        step();
        chk_out("lh2", 1, 6, 32'hFFFF_80FF, 0, 4);
        drive(1, 1, 5'd6, 2'd1, 3'd5, 32'h1000_0000, LDW, 0);
        step();
        chk_out("lhu0", 1, 6, 32'h0000_7F01, 0, 5);
        drive(1, 1, 5'd6, 2'd1, 3'd2, 32'h1000_0002, LDW, 0);
        step();
        chk("lw2.misalign", 64'(bus.misalign_err), 64'd1);
        chk("lw2.RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("lw2.count", 64'(bus.retired_count), 64'd6);
        drive(1, 1, 5'd6, 2'd1, 3'd1, 32'h1000_0001, LDW, 0);
        step();
        chk("lh1.misalign", 64'(bus.misalign_err), 64'd1);
        chk("lh1.RegWrite", 64'(bus.RegWrite), 64'd0);
        drive(1, 1, 5'd6, 2'd1, 3'd2, 32'h1000_0000, LDW, 0);
        step();
        chk_out("lw0", 1, 6, LDW, 0, 8);

        drive(1, 1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 0, 0);
        step();
        chk_out("r0", 0, 0, 32'hDEAD_BEEF, 0, 9);

        drive(1, 1, 5'd7, 2'd0, 3'd0, 32'hA5A5_0001, 0, 0);
        step();
        chk_out("pre_stall", 1, 7, 32'hA5A5_0001, 0, 10);
        bus.stall = 1'b1;
        drive(1, 1, 5'd9, 2'd0, 3'd0, 32'h5555_AAAA, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 1, 7, 32'hA5A5_0001, 0, 10);
        end
        bus.flush = 1'b1;
        step();
        chk_out("stall_flush", 0, 0, 0, 0, 10);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        drive(1, 1, 5'd31, 2'd2, 3'd0, 32'h0000_0044, 0, 32'h0040_0010);
        step();
        chk_out("link", 1, 31, 32'h0040_0010, 0, 11);
        drive(1, 1, 5'd4, 2'd3, 3'd0, 32'h0000_0044, LDW, 32'h0040_0010);
        step();
        chk_out("rsvd_sel", 0, 4, 0, 0, 12);
        drive(0, 1, 5'd3, 2'd0, 3'd0, 32'h0000_0077, 0, 0);
        step();
        chk_out("bubble_in", 0, 3, 32'h0000_0077, 0, 12);

        drive(1, 1, 5'd2, 2'd0, 3'd0, 32'h0000_0002, 0, 0);
        for (int i = 0; i < 3; i++) step();
        chk_out("count_max", 1, 2, 32'h0000_0002, 0, 15);
        step();
        chk_out("count_wrap", 1, 2, 32'h0000_0002, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
